// File: rtl/ifu_fetch_pair_pkg.sv
// Shared definitions for the dual-issue fetch stage: branch opcodes,
// instruction package bit positions, reset PC default and FSM encoding.
package ifu_fetch_pair_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam int          PKG_W_DEFAULT    = 128;

  // Branch-class major opcodes (inst[31:26])
  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;

  // Instruction package layout
  localparam int PKG_PC_LSB    = 96;
  localparam int PKG_INST1_LSB = 64;
  localparam int PKG_INST2_LSB = 32;
  localparam int PKG_V1_BIT    = 31;
  localparam int PKG_V2_BIT    = 30;
  localparam int PKG_BR1_BIT   = 29;
  localparam int PKG_PT1_BIT   = 28;
  localparam int PKG_BR2_BIT   = 27;
  localparam int PKG_PT2_BIT   = 26;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_e;

endpackage

// File: rtl/ifu_predecode.sv
// Static branch predecode for one instruction slot: classifies the opcode,
// predicts direction (unconditional taken, conditional backward taken) and
// computes the PC-relative target.
module ifu_predecode
  import ifu_fetch_pair_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] spc,
  output logic        br,
  output logic        pt,
  output logic [31:0] target
);

  logic [5:0]  opcode;
  logic [31:0] offs_b;
  logic [31:0] offs_cond;

  assign opcode    = inst[31:26];
  // b/bl carry a 26-bit offset split as {inst[9:0], inst[25:10]}
  assign offs_b    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign offs_cond = {{14{inst[25]}}, inst[25:10], 2'b00};

  // Classify the slot and pick the predicted target
  always_comb begin
    br     = 1'b0;
    pt     = 1'b0;
    target = spc + 32'd4;
    case (opcode)
      OP_JIRL: br = 1'b1;
      OP_B, OP_BL: begin
        br     = 1'b1;
        pt     = 1'b1;
        target = spc + offs_b;
      end
      OP_BEQ, OP_BNE: begin
        br     = 1'b1;
        pt     = inst[25];
        target = spc + offs_cond;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ifu_fetch_pair.sv
// Dual-issue fetch stage: single-outstanding request/response fetch of an
// aligned 64-bit pair, static branch prediction and a registered
// instruction package held until the decode stage consumes it.
module ifu_fetch_pair
  import ifu_fetch_pair_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PKG_W    = PKG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             inst_req_o,
  output logic [31:0]      inst_addr_o,
  input  logic             inst_addr_ok_i,
  input  logic             inst_data_ok_i,
  input  logic [63:0]      inst_rdata_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [PKG_W-1:0] inst_package_o,
  output logic             package_valid_o
);

  fetch_state_e     state_reg;
  logic [31:0]      pc_reg;
  logic             req_reg;
  logic [PKG_W-1:0] pkg_reg;
  logic             valid_reg;

  logic [31:0] slot_inst [2];
  logic [31:0] slot_pc   [2];
  logic [31:0] slot_tgt  [2];
  logic [1:0]  slot_br;
  logic [1:0]  slot_pt;

  logic             v2_next;
  logic             br2_next;
  logic             pt2_next;
  logic [31:0]      pc_seq;
  logic [31:0]      next_pc;
  logic [PKG_W-1:0] pkg_next;

  // An odd-word PC uses only the upper half of the pair
  assign slot_inst[0] = pc_reg[2] ? inst_rdata_i[63:32] : inst_rdata_i[31:0];
  assign slot_inst[1] = pc_reg[2] ? 32'h0 : inst_rdata_i[63:32];
  assign slot_pc[0]   = pc_reg;
  assign slot_pc[1]   = {pc_reg[31:3], 3'b100};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_predecode
      ifu_predecode u_predecode (
        .inst   (slot_inst[gi]),
        .spc    (slot_pc[gi]),
        .br     (slot_br[gi]),
        .pt     (slot_pt[gi]),
        .target (slot_tgt[gi])
      );
    end
  endgenerate

  // A predicted-taken slot1 squashes slot2 entirely
  assign v2_next  = ~pc_reg[2] & ~slot_pt[0];
  assign br2_next = v2_next & slot_br[1];
  assign pt2_next = v2_next & slot_pt[1];
  assign pc_seq   = {pc_reg[31:3], 3'b000} + 32'd8;

  // Predicted next fetch PC
  always_comb begin
    next_pc = pc_seq;
    if (slot_pt[0]) begin
      next_pc = slot_tgt[0];
    end else if (pt2_next) begin
      next_pc = slot_tgt[1];
    end
  end

  // Assemble the package for the pair currently on the response bus
  always_comb begin
    pkg_next                        = '0;
    pkg_next[PKG_PC_LSB +: 32]      = pc_reg;
    pkg_next[PKG_INST1_LSB +: 32]   = slot_inst[0];
    pkg_next[PKG_INST2_LSB +: 32]   = slot_inst[1];
    pkg_next[PKG_V1_BIT]            = 1'b1;
    pkg_next[PKG_V2_BIT]            = v2_next;
    pkg_next[PKG_BR1_BIT]           = slot_br[0];
    pkg_next[PKG_PT1_BIT]           = slot_pt[0];
    pkg_next[PKG_BR2_BIT]           = br2_next;
    pkg_next[PKG_PT2_BIT]           = pt2_next;
  end

  // Fetch FSM with registered request and package outputs; redirect wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_REQ;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      pkg_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (redirect_valid_i) begin
      pc_reg    <= redirect_pc_i;
      valid_reg <= 1'b0;
      pkg_reg   <= '0;
      case (state_reg)
        ST_REQ: begin
          // A request accepted this cycle still owes us a response
          if (req_reg && inst_addr_ok_i) begin
            state_reg <= ST_DROP;
            req_reg   <= 1'b0;
          end else begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
          end
        end
        ST_WAIT, ST_DROP: begin
          if (inst_data_ok_i) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
          end else begin
            state_reg <= ST_DROP;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_REQ;
          req_reg   <= 1'b1;
        end
      endcase
    end else begin
      case (state_reg)
        ST_REQ: begin
          req_reg <= 1'b1;
          if (req_reg && inst_addr_ok_i) begin
            state_reg <= ST_WAIT;
            req_reg   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (inst_data_ok_i) begin
            pkg_reg   <= pkg_next;
            valid_reg <= 1'b1;
            pc_reg    <= next_pc;
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            valid_reg <= 1'b0;
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
          end
        end
        ST_DROP: begin
          if (inst_data_ok_i) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_REQ;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign inst_req_o      = req_reg;
  assign inst_addr_o     = {pc_reg[31:3], 3'b000};
  assign inst_package_o  = pkg_reg;
  assign package_valid_o = valid_reg;

endmodule
